// File: rtl/mem_if_ctrl_mc_if.sv
// Signal bundle between mem_if_ctrl_mc and its requesters / external memory.
// The controller takes the master view; the environment takes the slave view.
interface mem_if_ctrl_mc_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 3
);
    logic [NUM_CH-1:0]          req_valid;
    logic [NUM_CH-1:0]          req_ready;
    logic [NUM_CH-1:0]          req_we;
    logic [NUM_CH*ADDR_W-1:0]   req_addr;
    logic [NUM_CH*DATA_W-1:0]   req_wdata;
    logic [NUM_CH*DATA_W/8-1:0] req_be;

    logic [NUM_CH-1:0]          rsp_valid;
    logic [DATA_W-1:0]          rsp_rdata;
    logic                       rsp_err;

    logic                       mem_valid;
    logic                       mem_ready;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic [DATA_W/8-1:0]        mem_be;
    logic [TAG_W-1:0]           mem_tag;

    logic                       mem_rsp_valid;
    logic [TAG_W-1:0]           mem_rsp_tag;
    logic [DATA_W-1:0]          mem_rsp_rdata;
    logic                       mem_rsp_err;

    logic [31:0]                stat_rd;
    logic [31:0]                stat_wr;
    logic [31:0]                stat_timeout;
    logic [31:0]                stat_stale;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_be, mem_tag,
        input  mem_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_rdata, mem_rsp_err,
        output stat_rd, stat_wr, stat_timeout, stat_stale
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be, mem_tag,
        output mem_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_rdata, mem_rsp_err,
        input  stat_rd, stat_wr, stat_timeout, stat_stale
    );
endinterface

// File: rtl/mem_if_ctrl_mc.sv
// Multi-channel memory controller: round-robin issue, in-order tag tracking,
// head-of-line timeout, stale-response dropping and performance counters.
module mem_if_ctrl_mc #(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int TAG_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input logic              clk,
    input logic              rst_n,
    mem_if_ctrl_mc_if.master bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic             we;
        logic [TAG_W-1:0] tag;
    } trk_entry_t;

    trk_entry_t        trk_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic [CH_W-1:0]   rr_q;
    logic [TAG_W-1:0]  tag_q;

    logic              iss_valid_q, iss_we_q;
    logic [ADDR_W-1:0] iss_addr_q;
    logic [DATA_W-1:0] iss_wdata_q;
    logic [BE_W-1:0]   iss_be_q;
    logic [TAG_W-1:0]  iss_tag_q;

    logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       stat_rd_q, stat_wr_q, stat_timeout_q, stat_stale_q;

    logic              can_grant, grant_any, accept;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_ch;
    trk_entry_t        head;
    logic              trk_nonempty, rsp_match, timeout_hit, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign accept = iss_valid_q && bus.mem_ready;

    // Round-robin search starting at rr_q; holding grants off during reset keeps req_ready low.
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_ch  = '0;
        grant_any = 1'b0;
        can_grant = rst_n && (!iss_valid_q || bus.mem_ready) &&
                    (count_q < CNT_W'(MAX_OUTSTANDING));
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_q) + k) % NUM_CH;
            if (can_grant && !grant_any && bus.req_valid[idx]) begin
                grant_any  = 1'b1;
                grant_ch   = CH_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    assign bus.req_ready = grant;

    always_comb begin
        head         = trk_mem_q[rd_ptr_q];
        trk_nonempty = (count_q != '0);
        rsp_match    = bus.mem_rsp_valid && trk_nonempty && (bus.mem_rsp_tag == head.tag);
        timeout_hit  = trk_nonempty && !rsp_match && (age_q == AGE_W'(TIMEOUT_CYCLES - 1));
        pop          = rsp_match || timeout_hit;
        push         = grant_any;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);

        // Age restarts whenever the head entry changes.
        if (pop || (push && !trk_nonempty)) age_d = '0;
        else if (trk_nonempty)              age_d = age_q + AGE_W'(1);
        else                                age_d = age_q;

        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (pop) begin
            rsp_valid_d[head.ch] = 1'b1;
            rsp_err_d            = rsp_match ? bus.mem_rsp_err : 1'b1;
            rsp_rdata_d          = (rsp_match && !head.we) ? bus.mem_rsp_rdata : '0;
        end
    end

    // NOTE: tracker storage has no reset; count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) trk_mem_q[wr_ptr_q] <= '{ch: grant_ch, we: bus.req_we[grant_ch], tag: tag_q};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            age_q          <= '0;
            rr_q           <= '0;
            tag_q          <= '0;
            iss_valid_q    <= 1'b0;
            iss_we_q       <= 1'b0;
            iss_addr_q     <= '0;
            iss_wdata_q    <= '0;
            iss_be_q       <= '0;
            iss_tag_q      <= '0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            stat_rd_q      <= '0;
            stat_wr_q      <= '0;
            stat_timeout_q <= '0;
            stat_stale_q   <= '0;
        end else begin
            count_q     <= count_d;
            age_q       <= age_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

            if (grant_any) begin
                iss_valid_q <= 1'b1;
                iss_we_q    <= bus.req_we[grant_ch];
                iss_addr_q  <= bus.req_addr[int'(grant_ch)*ADDR_W +: ADDR_W];
                iss_wdata_q <= bus.req_wdata[int'(grant_ch)*DATA_W +: DATA_W];
                iss_be_q    <= bus.req_be[int'(grant_ch)*BE_W +: BE_W];
                iss_tag_q   <= tag_q;
                tag_q       <= tag_q + TAG_W'(1);
                rr_q        <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
            end else if (accept) begin
                iss_valid_q <= 1'b0;
            end

            if (accept && !iss_we_q)                stat_rd_q      <= stat_rd_q + 32'd1;
            if (accept && iss_we_q)                 stat_wr_q      <= stat_wr_q + 32'd1;
            if (timeout_hit)                        stat_timeout_q <= stat_timeout_q + 32'd1;
            if (bus.mem_rsp_valid && !rsp_match)    stat_stale_q   <= stat_stale_q + 32'd1;
        end
    end

    assign bus.mem_valid    = iss_valid_q;
    assign bus.mem_we       = iss_we_q;
    assign bus.mem_addr     = iss_addr_q;
    assign bus.mem_wdata    = iss_wdata_q;
    assign bus.mem_be       = iss_be_q;
    assign bus.mem_tag      = iss_tag_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.stat_rd      = stat_rd_q;
    assign bus.stat_wr      = stat_wr_q;
    assign bus.stat_timeout = stat_timeout_q;
    assign bus.stat_stale   = stat_stale_q;
endmodule

// File: tb/tb_mem_if_ctrl_mc.sv
// Self-checking bench for mem_if_ctrl_mc: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based transaction model.
`timescale 1ns/1ps
module tb_mem_if_ctrl_mc;
    localparam int NUM_CH  = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int MAX_OUT = 4;
    localparam int TMO     = 16;
    localparam int TAG_W   = $clog2(MAX_OUT) + 1;
    localparam int BE_W    = DATA_W / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_if_ctrl_mc_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    mem_if_ctrl_mc #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(TMO), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Transaction-level model state.
    typedef struct { int ch; bit we; int tag; } ent_t;
    typedef struct { int tag; longint due; } pend_t;
    ent_t  trk[$];
    pend_t pend[$];
    bit                iv, iwe;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] iwdata;
    logic [BE_W-1:0]   ibe;
    int                itag, rr, next_tag;
    longint            cyc, head_start;
    logic [NUM_CH-1:0] e_rsp_valid;
    logic [DATA_W-1:0] e_rsp_rdata;
    bit                e_rsp_err;
    logic [31:0]       n_rd, n_wr, n_tmo, n_stale;
    bit                mem_auto;
    int                checks = 0;
    int                failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        trk.delete(); pend.delete();
        iv = 0; iwe = 0; iaddr = '0; iwdata = '0; ibe = '0; itag = 0;
        rr = 0; next_tag = 0; cyc = 0; head_start = 0;
        e_rsp_valid = '0; e_rsp_rdata = '0; e_rsp_err = 0;
        n_rd = '0; n_wr = '0; n_tmo = '0; n_stale = '0;
    endfunction

    function automatic int model_grant();
        if (!rst_n || (iv && !bus.mem_ready) || trk.size() >= MAX_OUT) return -1;
        for (int k = 0; k < NUM_CH; k++) begin
            int c = (rr + k) % NUM_CH;
            if (bus.req_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_update();
        int g     = model_grant();
        bit acc   = iv && bus.mem_ready;
        bit had   = trk.size() > 0;
        bit match = bus.mem_rsp_valid && had && (int'(bus.mem_rsp_tag) == trk[0].tag);
        bit tmo   = had && !match && (cyc - head_start == TMO - 1);
        e_rsp_valid = '0; e_rsp_rdata = '0; e_rsp_err = 0;
        if (match || tmo) begin
            e_rsp_valid[trk[0].ch] = 1'b1;
            e_rsp_err   = match ? bus.mem_rsp_err : 1'b1;
            e_rsp_rdata = (match && !trk[0].we) ? bus.mem_rsp_rdata : '0;
            if (tmo) n_tmo++;
            void'(trk.pop_front());
            if (trk.size() > 0) head_start = cyc + 1;
        end
        if (bus.mem_rsp_valid && !match) n_stale++;
        if (acc) begin
            if (iwe) n_wr++; else n_rd++;
            if (mem_auto && $urandom_range(0, 99) >= 5)
                pend.push_back('{tag: itag, due: cyc + longint'($urandom_range(1, 6))});
        end
        if (g >= 0) begin
            if (trk.size() == 0) head_start = cyc + 1;
            trk.push_back('{ch: g, we: bus.req_we[g], tag: next_tag});
            iv = 1; iwe = bus.req_we[g];
            iaddr  = bus.req_addr[g*ADDR_W +: ADDR_W];
            iwdata = bus.req_wdata[g*DATA_W +: DATA_W];
            ibe    = bus.req_be[g*BE_W +: BE_W];
            itag = next_tag;
            next_tag = (next_tag + 1) % (1 << TAG_W);
            rr = (g + 1) % NUM_CH;
        end else if (acc) begin
            iv = 0;
        end
        cyc++;
    endfunction

    task automatic compare_all();
        int g = model_grant();
        check("req_ready", bus.req_ready, (g >= 0) ? 64'(1 << g) : 64'd0);
        check("mem_valid", bus.mem_valid, iv);
        if (iv) begin
            check("mem_we", bus.mem_we, iwe);
            check("mem_addr", bus.mem_addr, iaddr);
            check("mem_wdata", bus.mem_wdata, iwdata);
            check("mem_be", bus.mem_be, ibe);
            check("mem_tag", bus.mem_tag, 64'(itag));
        end
        check("rsp_valid", bus.rsp_valid, e_rsp_valid);
        check("rsp_rdata", bus.rsp_rdata, e_rsp_rdata);
        check("rsp_err", bus.rsp_err, e_rsp_err);
        check("stat_rd", bus.stat_rd, n_rd);
        check("stat_wr", bus.stat_wr, n_wr);
        check("stat_timeout", bus.stat_timeout, n_tmo);
        check("stat_stale", bus.stat_stale, n_stale);
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_be = '0; bus.mem_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_tag = '0;
        bus.mem_rsp_rdata = '0; bus.mem_rsp_err = 1'b0;
    endtask

    task automatic clear_rsp();
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_tag = '0;
        bus.mem_rsp_rdata = '0; bus.mem_rsp_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        mem_auto = 0;
        pend.delete();
        bus.req_valid = '0;
        while ((trk.size() > 0 || iv) && n < 200) begin
            bus.mem_ready = 1'b1;
            clear_rsp();
            if (trk.size() > 0) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_tag   = TAG_W'(trk[0].tag);
                bus.mem_rsp_rdata = {$urandom(), $urandom()};
            end
            step();
            n++;
        end
        clear_rsp();
        checks++;
        if (trk.size() > 0 || iv) begin
            failures++;
            $display("FAIL drain: %0d entries left after %0d cycles", trk.size(), n);
        end
        step();
    endtask

    task automatic rand_step();
        int r;
        bus.req_valid = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
        bus.req_we    = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
        bus.req_addr  = {$urandom(), $urandom()};
        bus.req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.req_be    = 16'($urandom());
        bus.mem_ready = ($urandom_range(0, 99) < 70);
        clear_rsp();
        r = int'($urandom_range(0, 99));
        if (pend.size() > 0 && pend[0].due <= cyc && r < 60) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_tag   = TAG_W'(pend[0].tag);
            bus.mem_rsp_rdata = {$urandom(), $urandom()};
            bus.mem_rsp_err   = ($urandom_range(0, 9) == 0);
            void'(pend.pop_front());
        end else if (r >= 97) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_tag   = TAG_W'($urandom());
            bus.mem_rsp_rdata = {$urandom(), $urandom()};
        end
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_auto = 0;
        clear_inputs();
        model_reset();
        @(negedge clk);

        // Single read on ch0, answered three cycles after acceptance.
        do_reset();
        bus.req_valid = 2'b01; bus.req_addr = 64'h0000_0000_0000_0100; bus.mem_ready = 1'b1;
        #1 check("t1_ready", bus.req_ready, 64'h1);
        step();
        bus.req_valid = '0;
        check("t1_mem_valid", bus.mem_valid, 64'h1);
        check("t1_mem_addr", bus.mem_addr, 64'h100);
        check("t1_mem_tag", bus.mem_tag, 64'h0);
        step(); step(); step();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = '0; bus.mem_rsp_rdata = 64'hDEADBEEF;
        step();
        clear_rsp();
        check("t1_rsp_valid", bus.rsp_valid, 64'h1);
        check("t1_rsp_rdata", bus.rsp_rdata, 64'hDEADBEEF);
        check("t1_rsp_err", bus.rsp_err, 64'h0);
        check("t1_stat_rd", bus.stat_rd, 64'h1);
        step();

        // Two channels contend: alternate grants, tags 0..3, fifth request stalls.
        do_reset();
        bus.req_valid = 2'b11; bus.mem_ready = 1'b1;
        bus.req_addr = 64'h0000_2000_0000_1000;
        for (int i = 0; i < 4; i++) begin
            #1 check("t2_ready", bus.req_ready, (i % 2 == 0) ? 64'h1 : 64'h2);
            step();
            check("t2_tag", bus.mem_tag, 64'(i));
        end
        #1 check("t2_stall", bus.req_ready, 64'h0);
        step();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = '0;
        #1 check("t2_pop_same_cycle", bus.req_ready, 64'h0);
        step();
        clear_rsp();
        #1 check("t2_after_retire", bus.req_ready, 64'h1);
        drain();

        // Write held by mem_ready low: fields stable, no new grant, no count.
        do_reset();
        bus.req_valid = 2'b01; bus.req_we = 2'b01;
        bus.req_addr  = 64'h0000_0000_0000_0200;
        bus.req_wdata = {64'h0, 64'h0123_4567_89AB_CDEF};
        bus.req_be    = 16'h00A5;
        step();
        bus.req_valid = 2'b10;
        bus.req_wdata = {64'h0, 64'hFFFF_0000_FFFF_0000};
        for (int i = 0; i < 5; i++) begin
            #1 check("t3_ready", bus.req_ready, 64'h0);
            check("t3_mem_valid", bus.mem_valid, 64'h1);
            check("t3_mem_wdata", bus.mem_wdata, 64'h0123_4567_89AB_CDEF);
            check("t3_mem_be", bus.mem_be, 64'hA5);
            check("t3_mem_addr", bus.mem_addr, 64'h200);
            check("t3_stat_wr", bus.stat_wr, 64'h0);
            step();
        end
        bus.mem_ready = 1'b1;
        #1 check("t3_ready_on_accept", bus.req_ready, 64'h2);
        step();
        check("t3_stat_wr_after", bus.stat_wr, 64'h1);
        check("t3_next_tag", bus.mem_tag, 64'h1);
        drain();

        // Timeout with no response, then the late response is stale.
        do_reset();
        bus.req_valid = 2'b01; bus.mem_ready = 1'b1;
        step();
        bus.req_valid = '0;
        repeat (15) step();
        check("t4_no_rsp_yet", bus.rsp_valid, 64'h0);
        step();
        check("t4_rsp_valid", bus.rsp_valid, 64'h1);
        check("t4_rsp_err", bus.rsp_err, 64'h1);
        check("t4_rsp_rdata", bus.rsp_rdata, 64'h0);
        check("t4_stat_timeout", bus.stat_timeout, 64'h1);
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = '0; bus.mem_rsp_rdata = 64'h1234;
        step();
        clear_rsp();
        check("t4_stale_rsp", bus.rsp_valid, 64'h0);
        check("t4_stat_stale", bus.stat_stale, 64'h1);
        step();

        // Matching response in the timeout cycle wins.
        do_reset();
        bus.req_valid = 2'b01; bus.mem_ready = 1'b1;
        step();
        bus.req_valid = '0;
        repeat (15) step();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = '0; bus.mem_rsp_rdata = 64'hCAFE_F00D_0000_0042;
        step();
        clear_rsp();
        check("t5_rsp_valid", bus.rsp_valid, 64'h1);
        check("t5_rsp_err", bus.rsp_err, 64'h0);
        check("t5_rsp_rdata", bus.rsp_rdata, 64'hCAFE_F00D_0000_0042);
        check("t5_stat_timeout", bus.stat_timeout, 64'h0);
        step();

        // Asynchronous reset with three transactions in flight.
        do_reset();
        bus.req_valid = 2'b01; bus.mem_ready = 1'b1;
        repeat (3) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("t6_mem_valid", bus.mem_valid, 64'h0);
        check("t6_req_ready", bus.req_ready, 64'h0);
        check("t6_stat_rd", bus.stat_rd, 64'h0);
        step();
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_tag = TAG_W'(1);
        step();
        clear_rsp();
        check("t6_stat_stale", bus.stat_stale, 64'h1);
        check("t6_no_rsp", bus.rsp_valid, 64'h0);
        bus.req_valid = 2'b01;
        step();
        check("t6_tag_restart", bus.mem_tag, 64'h0);
        drain();

        // Randomized traffic with delayed, dropped and bogus memory responses.
        do_reset();
        mem_auto = 1;
        repeat (4000) rand_step();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_if_ctrl_mc.md
Name: mem_if_ctrl_mc

Overview:
- Multi-channel, pipelined memory interface controller between NUM_CH cache/requester ports and one external memory port (HBM/DDR/SRAM).
- Round-robin arbitration across channels; up to MAX_OUTSTANDING tagged transactions in flight.
- In-order tagged response matching; per-transaction timeout with error response; stale-response dropping; performance counters.
- Replaces the single-outstanding, single-port controller wherever several requesters share one memory port.

Parameters:
- NUM_CH, 2, number of requester channels (>=1).
- ADDR_W, 32, address width.
- DATA_W, 64, data width (multiple of 8).
- MAX_OUTSTANDING, 4, max tracked transactions (power of 2, >=1).
- TIMEOUT_CYCLES, 1024, cycles an entry may sit at tracker head before error retirement.
- TAG_W, $clog2(MAX_OUTSTANDING)+1, memory transaction tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel request accept
- req_we  in  NUM_CH  1=write, 0=read
- req_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  packed write data
- req_be  in  NUM_CH*DATA_W/8  packed byte enables
- rsp_valid  out  NUM_CH  one-cycle response pulse to channel
- rsp_rdata  out  DATA_W  shared response data
- rsp_err  out  1  response error (memory error or timeout)
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory request accept
- mem_we, mem_addr, mem_wdata, mem_be, mem_tag  out  1/ADDR_W/DATA_W/DATA_W/8/TAG_W  registered memory request fields
- mem_rsp_valid  in  1  memory response (reads and write acks)
- mem_rsp_tag  in  TAG_W  response tag
- mem_rsp_rdata  in  DATA_W  response data
- mem_rsp_err  in  1  memory-reported error
- stat_rd, stat_wr, stat_timeout, stat_stale  out  32 each  counters

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. While rst_n low: all outputs 0 (including req_ready), tracker emptied, tag counter 0, RR pointer 0, all counters 0. Reset mid-operation discards all in-flight state.
- Issue register: one entry holding mem_* fields. mem_valid stays high and fields stay stable until mem_valid && mem_ready.
- Grant condition: issue register empty or accepted this cycle, AND tracker count < MAX_OUTSTANDING (pops in the same cycle are not counted). Under that condition, grant the first valid channel at or after rr_ptr; then rr_ptr <= granted+1 mod NUM_CH.
- req_ready: req_ready[i] = grant[i], at most one bit set. req_ready may depend combinationally on req_valid.
- Grant latency: grant in cycle N loads the issue register; mem_valid is high in N+1. mem_tag = tag counter, which increments mod 2^TAG_W per grant.
- Tracker push on grant: in-order FIFO of {ch, we, tag}.
- Response matching: mem_rsp_valid with tracker non-empty and mem_rsp_tag == head.tag pops the head. Next cycle, rsp_valid[head.ch]=1, rsp_err=mem_rsp_err, and rsp_rdata = mem_rsp_rdata for reads, 0 for writes.
- Stale responses: mem_rsp_valid with tracker empty or tag mismatch is dropped; stat_stale++. No rsp_valid.
- Timeout: head_age resets to 0 when a new entry becomes head (including push into an empty tracker) and increments each cycle the tracker is non-empty. When head_age == TIMEOUT_CYCLES-1 and no matching response arrives that cycle, the head pops. Next cycle: rsp_valid[ch]=1, rsp_err=1, rsp_rdata=0; stat_timeout++.
- Simultaneous events: a matching response in the timeout cycle wins (normal retire, no timeout count). Push and pop in the same cycle are both performed.
- Response pulses: at most one rsp_valid per cycle. There is no response backpressure; requesters must accept.
- Counters: stat_rd / stat_wr increment on mem_valid && mem_ready for read / write. All counters wrap mod 2^32.
- Ordering: responses return to requesters in issue order across all channels.

Test Plan:
- Single read, ch0 addr 0x100; memory ready, responds with tag 0 and data 0xDEADBEEF after 3 cycles -> mem_valid one cycle after grant; rsp_valid[0] with 0xDEADBEEF, rsp_err=0; stat_rd=1.
- Both channels hold req_valid for 4 requests, rr_ptr=0 -> grant order ch0, ch1, ch0, ch1; tags 0,1,2,3; a 5th request is stalled (req_ready=0) until the first response retires.
- mem_ready held low 5 cycles with a write pending -> mem_* fields stable throughout; no further grant; stat_wr increments only on acceptance.
- No memory response, TIMEOUT_CYCLES=16 -> 16 cycles after the entry becomes head, rsp_valid with rsp_err=1, rdata 0; stat_timeout=1. A later response with that tag is dropped and stat_stale=1.
- Matching response arriving exactly in the timeout cycle -> normal response, rsp_err=mem_rsp_err; stat_timeout unchanged.
- rst_n asserted with 3 outstanding -> outputs 0 immediately. After release, a response with tag 1 is dropped (stat_stale=1) and the next grant uses tag 0.
